// File: rtl/geofence_host.sv
`default_nettype none
// ============================================================================
//  Module   : geofence_host
//  Purpose  : Host-side driver for the geofence checker. Buffers incoming
//             (X, Y, R) points, streams them as fixed-size objects onto the
//             checker's capture slots, owns the checker reset and reports
//             each verdict (or a missing verdict) as a numbered result.
//  Revision : 1.0 - initial release
// ============================================================================
module geofence_host #(
  parameter int NPTS    = 6,
  parameter int DEPTH   = 12,
  parameter int TIMEOUT = 64,
  parameter int IDXW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            pt_valid,
  output logic            pt_ready,
  input  logic [9:0]      pt_x,
  input  logic [9:0]      pt_y,
  input  logic [10:0]     pt_r,
  output logic            geo_reset,
  output logic [9:0]      geo_x,
  output logic [9:0]      geo_y,
  output logic [10:0]     geo_r,
  input  logic            geo_valid,
  input  logic            geo_inside,
  output logic            res_valid,
  output logic            res_inside,
  output logic            res_err,
  output logic [IDXW-1:0] res_idx,
  output logic            busy
);

  localparam int PW = 31;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(NPTS + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] NPTS_C   = CW'(NPTS);
  localparam logic [SW-1:0] LAST_PT  = SW'(NPTS - 1);
  localparam logic [TW-1:0] LAST_TIC = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  logic [1:0]      state;
  logic [1:0]      next_state;
  logic [PW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   pidx;
  logic [TW-1:0]   timer;
  logic [IDXW-1:0] idx;
  logic [PW-1:0]   head;
  logic            push;
  logic            load;
  logic            start_ok;
  logic            verdict;
  logic            timed_out;
  logic            to_hold;

  assign pt_ready = (count < DEPTH_C);
  assign push     = pt_valid && pt_ready;
  assign head     = mem[rd_ptr];

  // Point storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pt_x, pt_y, pt_r};
  end

  // FIFO pointers and occupancy; a pop is exactly a load onto the checker bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_ADR) ? '0 : wr_ptr + 1'b1;
      if (load) rd_ptr <= (rd_ptr == LAST_ADR) ? '0 : rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_HOLD;
    else       state <= next_state;
  end

  // Next-state logic; an object only starts once all its points are buffered.
  always_comb begin
    next_state = state;
    case (state)
      S_HOLD: if (start_ok) next_state = S_SEND;
      S_SEND: if (pidx == LAST_PT) next_state = S_WAIT;
      S_WAIT: begin
        if (verdict)        next_state = start_ok ? S_SEND : S_HOLD;
        else if (timed_out) next_state = S_HOLD;
      end
      default: next_state = S_HOLD;
    endcase
  end

  // Per-state control decode: bus loads, verdict capture, timeout, busy.
  always_comb begin
    start_ok  = enable && (count >= NPTS_C);
    load      = 1'b0;
    verdict   = 1'b0;
    timed_out = 1'b0;
    busy      = 1'b0;
    case (state)
      S_HOLD: load = start_ok;
      S_SEND: begin
        load = 1'b1;
        busy = 1'b1;
      end
      S_WAIT: begin
        busy      = 1'b1;
        verdict   = geo_valid;
        timed_out = !geo_valid && (timer == LAST_TIC);
        load      = geo_valid && start_ok;
      end
      default: ;
    endcase
    to_hold = timed_out || (verdict && !start_ok);
  end

  // Checker bus, checker reset, point/timer counters and the result stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      geo_reset  <= 1'b1;
      geo_x      <= '0;
      geo_y      <= '0;
      geo_r      <= '0;
      res_valid  <= 1'b0;
      res_inside <= 1'b0;
      res_err    <= 1'b0;
      res_idx    <= '0;
      idx        <= '0;
      pidx       <= '0;
      timer      <= '0;
    end else begin
      res_valid <= verdict || timed_out;
      if (verdict) begin
        res_inside <= geo_inside;
        res_err    <= 1'b0;
        res_idx    <= idx;
        idx        <= idx + 1'b1;
      end else if (timed_out) begin
        res_inside <= 1'b0;
        res_err    <= 1'b1;
        res_idx    <= idx;
        idx        <= idx + 1'b1;
      end

      // Back-to-back objects reload point 0 without pulsing the checker reset.
      if (load) begin
        {geo_x, geo_y, geo_r} <= head;
        geo_reset             <= 1'b0;
      end else if (to_hold) begin
        geo_x     <= '0;
        geo_y     <= '0;
        geo_r     <= '0;
        geo_reset <= 1'b1;
      end

      if (load) pidx <= (state == S_SEND) ? pidx + 1'b1 : SW'(1);

      // Timer is held at zero while sending so it starts fresh on WAIT entry.
      if (state == S_SEND)      timer <= '0;
      else if (state == S_WAIT) timer <= timer + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_geofence_host.sv
`default_nettype none
// ============================================================================
//  Module   : tb_geofence_host
//  Purpose  : Randomized bench for geofence_host with a protocol-level mock
//             checker and a queue-based model of buffered points and results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_geofence_host;

  localparam int NPTS    = 6;
  localparam int DEPTH   = 12;
  localparam int TIMEOUT = 64;
  localparam int IDXW    = 8;

  localparam int CK_IDLE = 0;
  localparam int CK_COLL = 1;
  localparam int CK_WAIT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            pt_valid = 1'b0;
  logic            pt_ready;
  logic [9:0]      pt_x = '0;
  logic [9:0]      pt_y = '0;
  logic [10:0]     pt_r = '0;
  logic            geo_reset;
  logic [9:0]      geo_x;
  logic [9:0]      geo_y;
  logic [10:0]     geo_r;
  logic            geo_valid = 1'b0;
  logic            geo_inside = 1'b0;
  logic            res_valid;
  logic            res_inside;
  logic            res_err;
  logic [IDXW-1:0] res_idx;
  logic            busy;

  geofence_host #(.NPTS(NPTS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_r(pt_r),
    .geo_reset(geo_reset), .geo_x(geo_x), .geo_y(geo_y), .geo_r(geo_r),
    .geo_valid(geo_valid), .geo_inside(geo_inside),
    .res_valid(res_valid), .res_inside(res_inside), .res_err(res_err),
    .res_idx(res_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: accepted points not yet seen on the checker bus, counters,
  // mock-checker phase and the single outstanding expected result.
  logic [30:0]     q[$];
  int              accepted = 0;
  int              popped = 0;
  int              cyc = 0;
  int              ck_st = CK_IDLE;
  int              ck_n = 0;
  bit              never = 0;
  int              valid_at = 0;
  bit              pend = 0;
  int              res_due = 0;
  logic [IDXW+1:0] exp_res = '0;
  bit              exp_res_to = 0;
  logic [IDXW-1:0] idx = '0;
  bit              chk_grst = 0;
  bit              exp_grst = 0;
  bit              chk_rst = 0;
  int              res_seen = 0;

  // Stimulus knobs.
  bit en = 0;
  int pv_pct = 0;
  int to_pct = 0;
  int lat_max = 1;
  bit junk = 0;
  bit rst_req = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: observe the DUT mid-cycle, then drive this cycle's inputs.
  task automatic step();
    int mc;
    bit start_ok;
    bit vnow;
    logic [30:0] ep;
    @(negedge clk);
    cyc++;

    if (chk_grst) begin
      check("geo_reset_next", geo_reset, exp_grst);
      chk_grst = 0;
    end
    if (chk_rst) begin
      check("reset_values",
            {geo_reset, geo_x, geo_y, geo_r, res_valid, res_idx, busy, pt_ready},
            {1'b1, 31'd0, 1'b0, 8'd0, 1'b0, 1'b1});
      chk_rst = 0;
    end

    if (res_valid) begin
      res_seen++;
      if (pend && cyc == res_due) begin
        check("result", {res_inside, res_err, res_idx}, exp_res);
        if (exp_res_to) check("timeout_geo_reset", geo_reset, 1'b1);
      end else begin
        check("res_unexpected", res_valid, 1'b0);
      end
      pend = 0;
    end else if (pend && cyc == res_due) begin
      check("res_missing", res_valid, 1'b1);
      pend = 0;
    end

    // Mock checker: captures the bus on each slot while its reset is low.
    if (geo_reset) begin
      ck_st = CK_IDLE;
      ck_n  = 0;
    end else if (ck_st != CK_WAIT) begin
      if (q.size() == 0) begin
        check("point_without_data", geo_reset, 1'b1);
      end else begin
        ep = q.pop_front();
        check("point", {geo_x, geo_y, geo_r}, ep);
      end
      popped++;
      ck_n++;
      ck_st = CK_COLL;
      if (ck_n == NPTS) begin
        ck_st = CK_WAIT;
        ck_n  = 0;
        if ($urandom_range(99) < to_pct) begin
          never      = 1;
          pend       = 1;
          res_due    = cyc + TIMEOUT;
          exp_res    = {1'b0, 1'b1, idx};
          exp_res_to = 1;
          idx++;
        end else begin
          never    = 0;
          valid_at = cyc + $urandom_range(lat_max, 1);
        end
      end
    end

    mc = accepted - popped;
    check("pt_ready", pt_ready, mc < DEPTH);

    if (rst_req) begin
      reset     = 1'b1;
      pt_valid  = 1'b0;
      geo_valid = 1'b0;
      q.delete();
      accepted = 0;
      popped   = 0;
      ck_st    = CK_IDLE;
      ck_n     = 0;
      pend     = 0;
      idx      = '0;
      chk_grst = 0;
      chk_rst  = 1;
    end else begin
      reset      = 1'b0;
      enable     = en;
      start_ok   = en && (mc >= NPTS);
      vnow       = 0;
      geo_valid  = 1'b0;
      geo_inside = 1'b0;
      if (ck_st == CK_WAIT && !never && cyc == valid_at) begin
        vnow       = 1;
        geo_valid  = 1'b1;
        geo_inside = 1'($urandom_range(1));
        pend       = 1;
        res_due    = cyc + 1;
        exp_res    = {geo_inside, 1'b0, idx};
        exp_res_to = 0;
        idx++;
        check("busy_in_wait", busy, 1'b1);
        ck_st = CK_COLL;
        ck_n  = 0;
      end else if (junk && ck_st != CK_WAIT && $urandom_range(7) == 0) begin
        geo_valid  = 1'b1;
        geo_inside = 1'b1;
      end
      if (ck_st == CK_IDLE || vnow) begin
        chk_grst = 1;
        exp_grst = !start_ok;
      end
      pt_valid = ($urandom_range(99) < pv_pct);
      pt_x     = 10'($urandom);
      pt_y     = 10'($urandom);
      pt_r     = 11'($urandom);
      if (pt_valid && mc < DEPTH) begin
        q.push_back({pt_x, pt_y, pt_r});
        accepted++;
      end
    end
  endtask

  initial begin
    int base;
    bit hit;

    // Reset and reset-value check.
    rst_req = 1;
    repeat (3) step();
    rst_req = 0;
    step();

    // Mixed traffic: random gaps, latencies, timeouts and stray verdict strobes.
    en = 1; pv_pct = 60; to_pct = 15; lat_max = 30; junk = 1;
    repeat (1500) step();

    // Fill with enable low, then release.
    en = 0; pv_pct = 100; to_pct = 0; lat_max = 10;
    repeat (150) step();
    check("full_not_ready", pt_ready, 1'b0);
    en = 1;
    repeat (60) step();

    // Reset in the middle of sending an object.
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      step();
      if (ck_st == CK_COLL && ck_n == 3) hit = 1;
    end
    check("reached_mid_send", hit, 1'b1);
    rst_req = 1;
    step();
    rst_req = 0;
    pv_pct = 0;
    repeat (100) step();

    // Back-to-back objects until the result index has wrapped.
    pv_pct = 100; lat_max = 1; junk = 0;
    base = res_seen;
    for (int i = 0; i < 5000 && (res_seen - base) < 260; i++) step();
    check("index_wrapped", (res_seen - base) >= 257, 1'b1);

    // Verdicts never arrive.
    to_pct = 100; lat_max = 5;
    repeat (400) step();

    // Drain so any outstanding result is checked.
    pv_pct = 0; to_pct = 0;
    repeat (200) step();
    check("no_result_outstanding", pend, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
